otf_quotient_converter: RTL and testbench
=========================================

Name: otf_quotient_converter

Overview:
- Downstream consumer of the on-line divider's serial quotient digit stream `q_value`.
- Performs on-the-fly conversion of radix-2 signed digits, MSD first, into a two's-complement fixed-point quotient.
- Needs no carry-propagate adder, discards the divider's on-line-delay digits, and presents a parallel quotient with a one-cycle valid pulse.

Parameters:
- N, 16: number of significant quotient digits converted per division.
- DELAY, 3: number of leading valid digits discarded after `start` (the divider's on-line delay).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new conversion and aborts any conversion in progress.
- digit_valid  input  1  `q_value` carries a digit this cycle.
- q_value  input  2  borrow-save digit {plus,minus}: 10 = +1, 01 = -1, 00 = 0, 11 = illegal (treated as 0).
- busy  output  1  high in SKIP or ACCUM.
- quot_valid  output  1  one-cycle pulse; `quotient` is final.
- quotient  output  N+1  two's complement; value = quotient·2^-N, range (-1,1).
- digit_cnt  output  log2(N+DELAY)+1  digits accepted since `start`.
- err_illegal  output  1  sticky; set on any accepted 11 digit, cleared by `start` or reset.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; Q=0; QM=all ones.
  - quotient=0, quot_valid=0, busy=0, digit_cnt=0, err_illegal=0.
- State machine, registered, one transition per clk edge:
  - IDLE: digits ignored. On `start`: clear registers, go to SKIP if DELAY>0, else ACCUM.
  - SKIP: each cycle with digit_valid increments digit_cnt; the digit is discarded. After the DELAY-th accepted digit, go to ACCUM.
  - ACCUM: each cycle with digit_valid increments digit_cnt and updates the Q/QM registers (width N+1, left shift, MSB dropped):
    - q=+1: Q<={Q[N-1:0],1}; QM<={Q[N-1:0],0}.
    - q=0 (00 or 11): Q<={Q[N-1:0],0}; QM<={QM[N-1:0],1}.
    - q=-1: Q<={QM[N-1:0],1}; QM<={QM[N-1:0],0}.
  - On the edge accepting the N-th ACCUM digit: quotient<=new Q, state<=IDLE. quot_valid is high for exactly the following cycle.
- Latency: quot_valid rises one cycle after the last digit is sampled. Total time is DELAY+N valid digits plus 1 cycle.
- `quotient` holds its value until the next completion or reset; it is not cleared by `start`.
- digit_valid may be deasserted at any time; conversion stalls with no state change.
- Boundary cases:
  - `start` coinciding with digit_valid: `start` wins, the digit is discarded, and registers reinitialise.
  - `start` mid-conversion: abort without a quot_valid pulse and restart.
  - `start` in the same cycle as the N-th digit: the restart wins and no quot_valid is produced.
  - Reset mid-conversion: immediate return to reset values; no pulse.
  - Digits arriving in IDLE after completion are ignored and digit_cnt holds.
  - digit_cnt saturates at N+DELAY until the next `start`.
- Illegal digit 11 is converted as 0 and sets err_illegal. err_illegal does not block quot_valid.

Test Plan:
- N=4, DELAY=2: `start`; digits 00,01 (skipped), then +1,0,-1,+1 back-to-back -> quot_valid one cycle after last digit; quotient=5'b00111 (7/16); digit_cnt=6.
- N=4, DELAY=0: digits -1,0,0,0 -> quotient=5'b11000 (-1/2). Digits -1,-1,-1,-1 on the next run -> quotient=5'b10001 (-15/16).
- Gapped stream: the +1,0,-1,+1 digits with digit_valid low for 3 cycles between each -> same result 5'b00111; busy high throughout; exactly one quot_valid pulse.
- Abort: `start`, two ACCUM digits, `start` again, then a full 4-digit 0,0,0,+1 stream -> single quot_valid; quotient=5'b00001; no pulse for the aborted run.
- Illegal/reset: digit 11 among the ACCUM digits -> treated as 0, err_illegal=1 until the next `start`. rst_n low mid-ACCUM -> all outputs zero immediately (QM all ones), no pulse, state IDLE.

Source files
------------

// File: rtl/otf_quotient_converter_if.sv
`default_nettype none
// ============================================================================
// Module   : otf_quotient_converter_if
// Brief    : Digit-stream and parallel-quotient bundle for the OTF converter.
// Revision : 1.0 - initial release
// ============================================================================
interface otf_quotient_converter_if #(
    parameter int N     = 16,
    parameter int DELAY = 3
);
    localparam int c_CNT_W = $clog2(N + DELAY) + 1;

    logic               start;
    logic               digit_valid;
    logic [1:0]         q_value;
    logic               busy;
    logic               quot_valid;
    logic [N:0]         quotient;
    logic [c_CNT_W-1:0] digit_cnt;
    logic               err_illegal;

    // master: the digit source; slave: the converter
    modport master (
        output start, digit_valid, q_value,
        input  busy, quot_valid, quotient, digit_cnt, err_illegal
    );

    modport slave (
        input  start, digit_valid, q_value,
        output busy, quot_valid, quotient, digit_cnt, err_illegal
    );
endinterface
`default_nettype wire

// File: rtl/otf_quotient_converter.sv
`default_nettype none
// ============================================================================
// Module   : otf_quotient_converter
// Brief    : On-the-fly conversion of an MSD-first radix-2 signed-digit
//            quotient stream into a two's-complement parallel quotient.
// Revision : 1.0 - initial release
// ============================================================================
module otf_quotient_converter #(
    parameter int N     = 16,
    parameter int DELAY = 3
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    otf_quotient_converter_if.slave      bus
);

    localparam int                 c_CNT_W     = $clog2(N + DELAY) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(N + DELAY);
    localparam logic [c_CNT_W-1:0] c_SKIP_LAST = c_CNT_W'(DELAY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_ACCUM = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [N:0]         r_q;
    logic [N:0]         r_qm;
    logic [N:0]         r_quotient;
    logic               r_quot_valid;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    logic [N:0]         w_q_next;
    logic [N:0]         w_qm_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_err_next;
    logic               w_done;
    logic               w_plus;
    logic               w_minus;
    logic               w_illegal;

    assign w_plus    = (bus.q_value == 2'b10);
    assign w_minus   = (bus.q_value == 2'b01);
    assign w_illegal = (bus.q_value == 2'b11);
    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Next-state and datapath update; start overrides everything, including
    // a digit or a completion arriving in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_qm_next    = r_qm;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_done       = 1'b0;

        if (bus.start) begin
            w_state_next = (DELAY > 0) ? S_SKIP : S_ACCUM;
            w_q_next     = '0;
            w_qm_next    = '1;
            w_cnt_next   = '0;
            w_err_next   = 1'b0;
        end else begin
            case (r_state)
                S_SKIP: begin
                    if (bus.digit_valid) begin
                        w_cnt_next = w_cnt_inc;
                        w_err_next = r_err | w_illegal;
                        if (w_cnt_inc == c_SKIP_LAST) begin
                            w_state_next = S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.digit_valid) begin
                        w_cnt_next = w_cnt_inc;
                        w_err_next = r_err | w_illegal;
                        // Q holds the prefix value, QM the prefix minus one ulp.
                        if (w_plus) begin
                            w_q_next  = {r_q[N-1:0], 1'b1};
                            w_qm_next = {r_q[N-1:0], 1'b0};
                        end else if (w_minus) begin
                            w_q_next  = {r_qm[N-1:0], 1'b1};
                            w_qm_next = {r_qm[N-1:0], 1'b0};
                        end else begin
                            w_q_next  = {r_q[N-1:0], 1'b0};
                            w_qm_next = {r_qm[N-1:0], 1'b1};
                        end
                        if (w_cnt_inc == c_CNT_MAX) begin
                            w_done       = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= '0;
            r_qm         <= '1;
            r_quotient   <= '0;
            r_quot_valid <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_qm         <= w_qm_next;
            r_quot_valid <= w_done;
            r_cnt        <= w_cnt_next;
            r_err        <= w_err_next;
            if (w_done) begin
                r_quotient <= w_q_next;
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.quot_valid  = r_quot_valid;
    assign bus.quotient    = r_quotient;
    assign bus.digit_cnt   = r_cnt;
    assign bus.err_illegal = r_err;

endmodule
`default_nettype wire

// File: tb/tb_otf_quotient_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_otf_quotient_converter
// Brief    : Self-checking bench: table vectors, corner sequences and random
//            streams against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otf_quotient_converter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otf_quotient_converter_if #(.N(4), .DELAY(2)) bus_a ();
    otf_quotient_converter_if #(.N(4), .DELAY(0)) bus_b ();

    otf_quotient_converter #(.N(4), .DELAY(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    otf_quotient_converter #(.N(4), .DELAY(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    logic [31:0] o_busy, o_qv, o_quot, o_cnt, o_err;

    typedef struct {
        int          sel;
        int          nd;
        logic [11:0] d;      // digits packed MSB-first, 2 bits each
        int          gap;
        logic [4:0]  q;
        int          cnt;
        logic        err;
    } vec_t;

    vec_t vecs [5];

    always @(negedge clk) begin
        if (bus_a.quot_valid === 1'b1) pulses_a++;
        if (bus_b.quot_valid === 1'b1) pulses_b++;
    end

    function automatic int get_pulses();
        return (sel == 0) ? pulses_a : pulses_b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        if (sel == 0) begin
            o_busy = 32'(bus_a.busy);      o_qv  = 32'(bus_a.quot_valid);
            o_quot = 32'(bus_a.quotient);  o_cnt = 32'(bus_a.digit_cnt);
            o_err  = 32'(bus_a.err_illegal);
        end else begin
            o_busy = 32'(bus_b.busy);      o_qv  = 32'(bus_b.quot_valid);
            o_quot = 32'(bus_b.quotient);  o_cnt = 32'(bus_b.digit_cnt);
            o_err  = 32'(bus_b.err_illegal);
        end
    endtask

    task automatic step(input logic st, input logic dv, input logic [1:0] q);
        bus_a.start = 1'b0; bus_a.digit_valid = 1'b0; bus_a.q_value = 2'b00;
        bus_b.start = 1'b0; bus_b.digit_valid = 1'b0; bus_b.q_value = 2'b00;
        if (sel == 0) begin
            bus_a.start = st; bus_a.digit_valid = dv; bus_a.q_value = q;
        end else begin
            bus_b.start = st; bus_b.digit_valid = dv; bus_b.q_value = q;
        end
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
            check("busy_in_gap", o_busy, 32'd1);
        end
    endtask

    function automatic logic [1:0] dig(input logic [11:0] d, input int k);
        return d[11 - 2*k -: 2];
    endfunction

    // Reference: quotient = sum(d_k * 2^-k); 11 counts as 0
    function automatic logic [4:0] ref_quot(input logic [11:0] d, input int nd, input int skip);
        int v = 0;
        logic [31:0] t;
        for (int k = skip; k < nd; k++) begin
            if (dig(d, k) == 2'b10) v += (1 << (3 - (k - skip)));
            if (dig(d, k) == 2'b01) v -= (1 << (3 - (k - skip)));
        end
        t = v;
        return t[4:0];
    endfunction

    task automatic feed(input logic [11:0] d, input int from, input int to, input int gap);
        for (int k = from; k < to; k++) begin
            step(1'b0, 1'b1, dig(d, k));
            if (k < to - 1) idle_gap(gap);
        end
    endtask

    initial begin
        int p0;
        logic [11:0] d;
        int nd, skip;
        logic exp_err;

        vecs[0] = '{0, 6, 12'b00_01_10_00_01_10, 0, 5'b00111, 6, 1'b0};
        vecs[1] = '{1, 4, 12'b01_00_00_00_00_00, 0, 5'b11000, 4, 1'b0};
        vecs[2] = '{1, 4, 12'b01_01_01_01_00_00, 0, 5'b10001, 4, 1'b0};
        vecs[3] = '{0, 6, 12'b00_01_10_00_01_10, 3, 5'b00111, 6, 1'b0};
        vecs[4] = '{0, 6, 12'b00_00_10_11_01_10, 0, 5'b00111, 6, 1'b1};

        // Reset values while rst_n is held low
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b10);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            sample();
            check("rst_quot", o_quot, 0); check("rst_qv", o_qv, 0);
            check("rst_busy", o_busy, 0); check("rst_cnt", o_cnt, 0);
            check("rst_err", o_err, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        sel = 0;
        step(1'b0, 1'b1, 2'b10);
        check("idle_ignores_digit", o_cnt, 0);

        // Table-driven conversions
        for (int i = 0; i < 5; i++) begin
            sel = vecs[i].sel;
            p0 = get_pulses();
            step(1'b1, 1'b0, 2'b00);
            check("start_busy", o_busy, 1);
            feed(vecs[i].d, 0, vecs[i].nd, vecs[i].gap);
            check("vec_qv", o_qv, 1);
            check("vec_quot", o_quot, 32'(vecs[i].q));
            check("vec_cnt", o_cnt, 32'(vecs[i].cnt));
            check("vec_err", o_err, 32'(vecs[i].err));
            step(1'b0, 1'b0, 2'b00);
            check("vec_qv_drop", o_qv, 0);
            check("vec_busy_idle", o_busy, 0);
            check("vec_quot_hold", o_quot, 32'(vecs[i].q));
            check("vec_one_pulse", 32'(get_pulses() - p0), 1);
        end

        // Sticky error until start; start leaves quotient untouched
        sel = 0;
        check("err_sticky", o_err, 1);
        p0 = get_pulses();
        step(1'b1, 1'b0, 2'b00);
        check("start_clr_err", o_err, 0);
        check("start_keeps_quot", o_quot, 32'h07);

        // Abort mid-ACCUM, restart coinciding with a digit
        feed(12'b00_00_10_10_00_00, 0, 4, 0);
        check("abort_cnt_before", o_cnt, 4);
        step(1'b1, 1'b1, 2'b10);
        check("restart_cnt", o_cnt, 0);
        check("restart_busy", o_busy, 1);
        feed(12'b00_00_00_00_00_10, 0, 6, 0);
        check("abort_quot", o_quot, 32'h01);
        step(1'b0, 1'b0, 2'b00);
        check("abort_one_pulse", 32'(get_pulses() - p0), 1);

        // Start in the same cycle as the N-th digit
        p0 = get_pulses();
        step(1'b1, 1'b0, 2'b00);
        feed(12'b00_00_10_10_10_00, 0, 5, 0);
        step(1'b1, 1'b1, 2'b10);
        check("nth_start_qv", o_qv, 0);
        check("nth_start_cnt", o_cnt, 0);
        step(1'b0, 1'b0, 2'b00);
        check("nth_start_qv2", o_qv, 0);
        check("nth_start_quot", o_quot, 32'h01);
        check("nth_start_nopulse", 32'(get_pulses() - p0), 0);

        // Completion then saturation: digits after completion are ignored
        p0 = get_pulses();
        step(1'b1, 1'b0, 2'b00);
        feed(12'b00_00_01_01_01_01, 0, 6, 1);
        check("sat_quot", o_quot, 32'h11);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b10);
        check("sat_cnt", o_cnt, 6);
        check("sat_busy", o_busy, 0);
        check("sat_one_pulse", 32'(get_pulses() - p0), 1);

        // Asynchronous reset mid-ACCUM
        p0 = get_pulses();
        step(1'b1, 1'b0, 2'b00);
        feed(12'b00_00_10_10_00_00, 0, 4, 0);
        #2 rst_n = 1'b0;
        #1 sample();
        check("arst_quot", o_quot, 0); check("arst_busy", o_busy, 0);
        check("arst_cnt", o_cnt, 0);   check("arst_qv", o_qv, 0);
        @(negedge clk) rst_n = 1'b1;
        step(1'b1, 1'b0, 2'b00);
        feed(12'b00_00_01_00_00_00, 0, 6, 0);
        check("post_rst_quot", o_quot, 32'h18);
        step(1'b0, 1'b0, 2'b00);
        check("arst_pulses", 32'(get_pulses() - p0), 1);

        // Randomized streams against the arithmetic model
        for (int r = 0; r < 60; r++) begin
            sel  = r % 2;
            skip = (sel == 0) ? 2 : 0;
            nd   = skip + 4;
            d    = '0;
            exp_err = 1'b0;
            for (int k = 0; k < nd; k++) begin
                if (k < skip) d[11 - 2*k -: 2] = 2'($urandom_range(0, 2));
                else          d[11 - 2*k -: 2] = 2'($urandom_range(0, 3));
                if (k >= skip && d[11 - 2*k -: 2] == 2'b11) exp_err = 1'b1;
            end
            p0 = get_pulses();
            if ($urandom_range(0, 3) == 0) begin
                step(1'b1, 1'b0, 2'b00);
                feed(12'($urandom), 0, $urandom_range(1, nd - 1), 1);
            end
            step(1'b1, 1'b0, 2'b00);
            feed(d, 0, nd, $urandom_range(0, 2));
            check("rnd_qv", o_qv, 1);
            check("rnd_quot", o_quot, 32'(ref_quot(d, nd, skip)));
            check("rnd_cnt", o_cnt, 32'(nd));
            check("rnd_err", o_err, 32'(exp_err));
            step(1'b0, 1'b0, 2'b00);
            check("rnd_one_pulse", 32'(get_pulses() - p0), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
